// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Free-running horizontal/vertical counters produce raw active/sync flags.
// The flags pass through a PIPE-deep delay line so they line up with pixel
// data returned by a pixel source of the same latency. A final output
// register then drives the syncs, blank_n and the masked colour channels.
// Every piece of state advances only when en=1.
// H_TOTAL and V_TOTAL must not exceed 1024. PIPE must be in 0..4.

module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 8,
  parameter int   PIPE     = 1
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [COLOR_W-1:0] in_pixel_r,
  input  logic [COLOR_W-1:0] in_pixel_g,
  input  logic [COLOR_W-1:0] in_pixel_b,
  output logic [9:0]         hcount,
  output logic [9:0]         vcount,
  output logic               frame_start,
  output logic [15:0]        frame_count,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries are 11 bits wide so a limit of exactly 1024 still compares
  // correctly against the 10-bit counters.
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_hcount;
  logic [9:0]  r_vcount;
  logic [15:0] r_frame_count;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;

  // Raw flags, packed as {active, hsync_asserted, vsync_asserted}.
  // Syncs stay in asserted-true form until the output register applies
  // the polarity, so the delay line resets to all-zero for "inactive".
  logic [2:0]  w_raw;
  logic [2:0]  w_dly;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_blank_n;
  logic [COLOR_W-1:0] r_vga_r;
  logic [COLOR_W-1:0] r_vga_g;
  logic [COLOR_W-1:0] r_vga_b;

  assign w_h_wrap = (r_hcount == H_LAST);
  assign w_v_wrap = (r_vcount == V_LAST);
  assign w_h_ext  = {1'b0, r_hcount};
  assign w_v_ext  = {1'b0, r_vcount};

  assign w_raw[2] = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
  assign w_raw[1] = (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
  // Derived from vcount alone, so it can only change on the hcount wrap.
  assign w_raw[0] = (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);

  // Raster counters: hcount every enabled cycle, vcount and frame_count on wraps.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_frame_count <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, so the nested wrap tests below see the old counts.
      if (w_h_wrap) begin
        r_hcount <= '0;
        if (w_v_wrap) begin
          r_vcount      <= '0;
          r_frame_count <= r_frame_count + 16'd1;
        end else begin
          r_vcount <= r_vcount + 10'd1;
        end
      end else begin
        r_hcount <= r_hcount + 10'd1;
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_no_dly
      assign w_dly = w_raw;
    end else begin : g_dly
      logic [2:0] r_dly [PIPE];

      // Delay line matching the pixel-source latency; shifts only when enabled.
      always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
          // NOTE: this small shift register is reset on purpose: the first
          // PIPE enabled cycles after reset must shift out inactive flags,
          // not stale syncs or a visible pixel from the aborted frame.
          for (int i = 0; i < PIPE; i++) begin
            r_dly[i] <= '0;
          end
        end else if (en) begin
          r_dly[0] <= w_raw;
          for (int i = 1; i < PIPE; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_dly = r_dly[PIPE-1];
    end
  endgenerate

  // Output register: applies sync polarity and blanks colour outside the active area.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync   <= ~HS_POL;
      r_vsync   <= ~VS_POL;
      r_blank_n <= 1'b0;
      r_vga_r   <= '0;
      r_vga_g   <= '0;
      r_vga_b   <= '0;
    end else if (en) begin
      r_hsync   <= w_dly[1] ? HS_POL : ~HS_POL;
      r_vsync   <= w_dly[0] ? VS_POL : ~VS_POL;
      r_blank_n <= w_dly[2];
      r_vga_r   <= w_dly[2] ? in_pixel_r : '0;
      r_vga_g   <= w_dly[2] ? in_pixel_g : '0;
      r_vga_b   <= w_dly[2] ? in_pixel_b : '0;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_count = r_frame_count;
  assign frame_start = en && (r_hcount == '0) && (r_vcount == '0);
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign VGA_R       = r_vga_r;
  assign VGA_G       = r_vga_g;
  assign VGA_B       = r_vga_b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// Four instances: the default 640x480 timing, and a small 16x11 raster in
// three latency/polarity variants so whole frames fit in a short run.
// A reference raster model pushes the expected output word for every
// enabled cycle into a queue; the word is popped and compared once the
// DUT has produced it, and held outputs are compared during en=0 cycles.

module tb_vga_timing_gen;

  // Small raster geometry: 16 pixels x 11 lines.
  localparam int S_HA = 8;
  localparam int S_HF = 2;
  localparam int S_HS = 3;
  localparam int S_HB = 3;
  localparam int S_VA = 6;
  localparam int S_VF = 2;
  localparam int S_VS = 1;
  localparam int S_VB = 2;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int pipe;
    bit hp; bit vp;
  } cfg_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    int h;
    int v;
  } coord_t;

  logic       vga_clk;
  logic       rst_n;
  logic       en_v [4];
  logic [7:0] pr   [4];
  logic [7:0] pg   [4];
  logic [7:0] pb   [4];
  logic [9:0] hc   [4];
  logic [9:0] vc   [4];
  logic       fs   [4];
  logic [15:0] fc  [4];
  logic       hs   [4];
  logic       vs   [4];
  logic       bl   [4];
  logic [7:0] vr   [4];
  logic [7:0] vg   [4];
  logic [7:0] vb   [4];

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cur;
  cfg_t   cfg;
  int     mh;
  int     mv;
  logic [15:0] mfc;
  exp_t   exp_q [$];
  coord_t crd_q [$];
  exp_t   last_exp;

  vga_timing_gen dut0 (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en_v[0]),
    .in_pixel_r(pr[0]), .in_pixel_g(pg[0]), .in_pixel_b(pb[0]),
    .hcount(hc[0]), .vcount(vc[0]), .frame_start(fs[0]), .frame_count(fc[0]),
    .hsync(hs[0]), .vsync(vs[0]), .blank_n(bl[0]),
    .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vb[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .PIPE(1)
  ) dut1 (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en_v[1]),
    .in_pixel_r(pr[1]), .in_pixel_g(pg[1]), .in_pixel_b(pb[1]),
    .hcount(hc[1]), .vcount(vc[1]), .frame_start(fs[1]), .frame_count(fc[1]),
    .hsync(hs[1]), .vsync(vs[1]), .blank_n(bl[1]),
    .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vb[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .PIPE(0)
  ) dut2 (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en_v[2]),
    .in_pixel_r(pr[2]), .in_pixel_g(pg[2]), .in_pixel_b(pb[2]),
    .hcount(hc[2]), .vcount(vc[2]), .frame_start(fs[2]), .frame_count(fc[2]),
    .hsync(hs[2]), .vsync(vs[2]), .blank_n(bl[2]),
    .VGA_R(vr[2]), .VGA_G(vg[2]), .VGA_B(vb[2])
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .PIPE(4)
  ) dut3 (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en_v[3]),
    .in_pixel_r(pr[3]), .in_pixel_g(pg[3]), .in_pixel_b(pb[3]),
    .hcount(hc[3]), .vcount(vc[3]), .frame_start(fs[3]), .frame_count(fc[3]),
    .hsync(hs[3]), .vsync(vs[3]), .blank_n(bl[3]),
    .VGA_R(vr[3]), .VGA_G(vg[3]), .VGA_B(vb[3])
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic cfg_t get_cfg(input int d);
    cfg_t c;
    if (d == 0) begin
      c = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
            pipe: 1, hp: 1'b0, vp: 1'b0};
    end else begin
      c = '{ha: S_HA, hf: S_HF, hs: S_HS, hb: S_HB, va: S_VA, vf: S_VF, vs: S_VS, vb: S_VB,
            pipe: 1, hp: 1'b0, vp: 1'b0};
      if (d == 2) begin c.pipe = 0; c.hp = 1'b1; c.vp = 1'b1; end
      if (d == 3) begin c.pipe = 4; c.hp = 1'b1; c.vp = 1'b1; end
    end
    return c;
  endfunction

  function automatic exp_t inactive_out();
    exp_t e;
    e.hs = ~cfg.hp;
    e.vs = ~cfg.vp;
    e.bl = 1'b0;
    e.r  = 8'h00;
    e.g  = 8'h00;
    e.b  = 8'h00;
    return e;
  endfunction

  function automatic exp_t model_out(input int h, input int v);
    exp_t e;
    bit act, hsa, vsa;
    act = (h < cfg.ha) && (v < cfg.va);
    hsa = (h >= cfg.ha + cfg.hf) && (h < cfg.ha + cfg.hf + cfg.hs);
    vsa = (v >= cfg.va + cfg.vf) && (v < cfg.va + cfg.vf + cfg.vs);
    e.hs = hsa ? cfg.hp : ~cfg.hp;
    e.vs = vsa ? cfg.vp : ~cfg.vp;
    e.bl = act;
    e.r  = act ? 8'(h) : 8'h00;
    e.g  = act ? 8'(v) : 8'h00;
    e.b  = act ? 8'hA5 : 8'h00;
    return e;
  endfunction

  task automatic model_init();
    coord_t c;
    mh  = 0;
    mv  = 0;
    mfc = 16'h0000;
    exp_q.delete();
    crd_q.delete();
    c.h = 0;
    c.v = 0;
    for (int i = 0; i < cfg.pipe; i++) begin
      exp_q.push_back(inactive_out());
      crd_q.push_back(c);
    end
    last_exp = inactive_out();
  endtask

  // Pulses reset for all instances and selects instance d for the next test.
  task automatic do_reset(input int d);
    cur = d;
    cfg = get_cfg(d);
    for (int i = 0; i < 4; i++) en_v[i] = 1'b0;
    rst_n = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    rst_n = 1'b1;
    model_init();
  endtask

  // One clock of the selected instance: checks counters before the edge,
  // feeds the pixel for the coordinate PIPE cycles back, then compares outputs.
  task automatic drive_cycle(input bit e);
    coord_t c;
    coord_t nc;
    int ht;
    int vt;
    ht = cfg.ha + cfg.hf + cfg.hs + cfg.hb;
    vt = cfg.va + cfg.vf + cfg.vs + cfg.vb;
    en_v[cur] = e;
    if (e) begin
      nc.h = mh;
      nc.v = mv;
      crd_q.push_back(nc);
      c = crd_q.pop_front();
      pr[cur] = 8'(c.h);
      pg[cur] = 8'(c.v);
      pb[cur] = 8'hA5;
    end
    #1;
    n_tests++;
    if (hc[cur] !== 10'(mh) || vc[cur] !== 10'(mv) || fc[cur] !== mfc ||
        fs[cur] !== (e && mh == 0 && mv == 0)) begin
      n_fail++;
      $display("FAIL counters d%0d: got h=%0d v=%0d fc=%0d fs=%b, want h=%0d v=%0d fc=%0d fs=%b",
               cur, hc[cur], vc[cur], fc[cur], fs[cur], mh, mv, mfc, (e && mh == 0 && mv == 0));
    end
    if (e) begin
      exp_q.push_back(model_out(mh, mv));
      if (mh == ht - 1) begin
        mh = 0;
        if (mv == vt - 1) begin
          mv  = 0;
          mfc = mfc + 16'd1;
        end else begin
          mv = mv + 1;
        end
      end else begin
        mh = mh + 1;
      end
    end
    @(posedge vga_clk);
    @(negedge vga_clk);
    if (e) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard d%0d: got empty queue, want an expected entry", cur);
      end else begin
        last_exp = exp_q.pop_front();
      end
    end
    n_tests++;
    if (hs[cur] !== last_exp.hs || vs[cur] !== last_exp.vs || bl[cur] !== last_exp.bl ||
        vr[cur] !== last_exp.r || vg[cur] !== last_exp.g || vb[cur] !== last_exp.b) begin
      n_fail++;
      $display("FAIL outputs d%0d at h=%0d v=%0d: got hs=%b vs=%b bl=%b rgb=%h/%h/%h, want hs=%b vs=%b bl=%b rgb=%h/%h/%h",
               cur, hc[cur], vc[cur], hs[cur], vs[cur], bl[cur], vr[cur], vg[cur], vb[cur],
               last_exp.hs, last_exp.vs, last_exp.bl, last_exp.r, last_exp.g, last_exp.b);
    end
  endtask

  task automatic test_reset();
    cfg_t c;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 4; d++) begin
      c = get_cfg(d);
      n_tests++;
      if (hc[d] !== 10'd0 || vc[d] !== 10'd0 || fc[d] !== 16'd0 || fs[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_counters d%0d: got h=%0d v=%0d fc=%0d fs=%b, want 0 0 0 0",
                 d, hc[d], vc[d], fc[d], fs[d]);
      end
      n_tests++;
      if (hs[d] !== ~c.hp || vs[d] !== ~c.vp || bl[d] !== 1'b0 ||
          vr[d] !== 8'd0 || vg[d] !== 8'd0 || vb[d] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs d%0d: got hs=%b vs=%b bl=%b rgb=%h/%h/%h, want hs=%b vs=%b bl=0 rgb=0",
                 d, hs[d], vs[d], bl[d], vr[d], vg[d], vb[d], ~c.hp, ~c.vp);
      end
    end
  endtask

  // Default timing, three full lines: hsync window and pixel pass-through.
  task automatic test_default_lines();
    int first_h;
    int hs_cnt;
    do_reset(0);
    first_h = -1;
    hs_cnt  = 0;
    for (int k = 1; k <= 2400; k++) begin
      drive_cycle(1'b1);
      if (k <= 800 && hs[0] === 1'b0) begin
        hs_cnt++;
        if (first_h < 0) first_h = int'(hc[0]);
      end
    end
    n_tests++;
    if (first_h != 658) begin
      n_fail++;
      $display("FAIL hsync_start: got first low at hcount=%0d, want 658", first_h);
    end
    n_tests++;
    if (hs_cnt != 96) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d low cycles, want 96", hs_cnt);
    end
    n_tests++;
    if (vc[0] !== 10'd3 || hc[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL line_count: got h=%0d v=%0d, want h=0 v=3", hc[0], vc[0]);
    end
  endtask

  // Small raster, two complete frames: frame length, vsync lines, frame_count.
  task automatic test_frames();
    int vs_cnt;
    int vs_h;
    int vs_v;
    do_reset(1);
    vs_cnt = 0;
    vs_h   = -1;
    vs_v   = -1;
    for (int k = 1; k <= 352; k++) begin
      drive_cycle(1'b1);
      if (vs[1] === 1'b0) begin
        vs_cnt++;
        if (vs_h < 0) begin
          vs_h = int'(hc[1]);
          vs_v = int'(vc[1]);
        end
      end
      if (k == 176) begin
        n_tests++;
        if (fc[1] !== 16'd1 || hc[1] !== 10'd0 || vc[1] !== 10'd0) begin
          n_fail++;
          $display("FAIL frame_len: got fc=%0d h=%0d v=%0d after 176 cycles, want 1 0 0",
                   fc[1], hc[1], vc[1]);
        end
      end
    end
    n_tests++;
    if (fc[1] !== 16'd2) begin
      n_fail++;
      $display("FAIL frame_count_2: got %0d, want 2", fc[1]);
    end
    n_tests++;
    if (vs_cnt != 32) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d asserted cycles, want 32", vs_cnt);
    end
    n_tests++;
    if (vs_h != 2 || vs_v != S_VA + S_VF) begin
      n_fail++;
      $display("FAIL vsync_start: got first at h=%0d v=%0d, want h=2 v=%0d", vs_h, vs_v, S_VA + S_VF);
    end
  endtask

  // PIPE=0 and PIPE=4 with high-true syncs: latency of sync and blank.
  task automatic test_pipe_pol();
    int first_hs;
    int first_bl;
    int vs_cnt;
    for (int d = 2; d <= 3; d++) begin
      do_reset(d);
      first_hs = -1;
      first_bl = -1;
      vs_cnt   = 0;
      for (int k = 1; k <= 200; k++) begin
        drive_cycle(1'b1);
        if (hs[d] === 1'b1 && first_hs < 0) first_hs = int'(hc[d]);
        if (bl[d] === 1'b1 && first_bl < 0) first_bl = int'(hc[d]);
        if (vs[d] === 1'b1) vs_cnt++;
      end
      n_tests++;
      if (first_hs != S_HA + S_HF + cfg.pipe + 1) begin
        n_fail++;
        $display("FAIL pipe_hsync d%0d: got first high at h=%0d, want %0d",
                 d, first_hs, S_HA + S_HF + cfg.pipe + 1);
      end
      n_tests++;
      if (first_bl != cfg.pipe + 1) begin
        n_fail++;
        $display("FAIL pipe_blank d%0d: got first visible at h=%0d, want %0d",
                 d, first_bl, cfg.pipe + 1);
      end
      n_tests++;
      if (vs_cnt != 16) begin
        n_fail++;
        $display("FAIL pipe_vsync d%0d: got %0d high cycles, want 16", d, vs_cnt);
      end
    end
  endtask

  // en pulsed one cycle in three across the 799 -> 0 line wrap.
  task automatic test_en_stall();
    logic [9:0] v_before;
    do_reset(0);
    for (int k = 0; k < 790; k++) drive_cycle(1'b1);
    v_before = vc[0];
    for (int k = 0; k < 60; k++) drive_cycle(k % 3 == 0);
    n_tests++;
    if (int'(vc[0]) - int'(v_before) != 1) begin
      n_fail++;
      $display("FAIL stall_vinc: got vcount %0d -> %0d, want one increment", v_before, vc[0]);
    end
    for (int k = 0; k < 10; k++) drive_cycle(1'b1);
    n_tests++;
    if (hc[0] !== 10'd20 || vc[0] !== 10'd1) begin
      n_fail++;
      $display("FAIL stall_resume: got h=%0d v=%0d, want h=20 v=1", hc[0], vc[0]);
    end
  endtask

  // Asynchronous reset in the middle of a frame, then restart at (0,0).
  task automatic test_reset_mid();
    do_reset(1);
    for (int k = 0; k < 53; k++) drive_cycle(1'b1);
    n_tests++;
    if (hc[1] !== 10'd5 || vc[1] !== 10'd3 || bl[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: got h=%0d v=%0d bl=%b, want h=5 v=3 bl=1", hc[1], vc[1], bl[1]);
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (hc[1] !== 10'd0 || vc[1] !== 10'd0 || bl[1] !== 1'b0 || hs[1] !== 1'b1 ||
        vs[1] !== 1'b1 || vr[1] !== 8'd0 || vg[1] !== 8'd0 || vb[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got h=%0d v=%0d bl=%b hs=%b vs=%b rgb=%h/%h/%h, want 0 0 0 1 1 0",
               hc[1], vc[1], bl[1], hs[1], vs[1], vr[1], vg[1], vb[1]);
    end
    en_v[1] = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    rst_n = 1'b1;
    model_init();
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    n_tests++;
    if (bl[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_blank: got blank_n=%b two cycles after restart, want 1", bl[1]);
    end
    for (int k = 0; k < 20; k++) drive_cycle(1'b1);
  endtask

  // frame_count wrap from 16'hFFFF to 0 on the next full-frame edge.
  task automatic test_frame_wrap();
    do_reset(1);
    force dut1.r_frame_count = 16'hFFFF;
    @(negedge vga_clk);
    release dut1.r_frame_count;
    mfc = 16'hFFFF;
    for (int k = 0; k < 175; k++) drive_cycle(1'b1);
    n_tests++;
    if (fc[1] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_pre: got frame_count=%h, want ffff", fc[1]);
    end
    drive_cycle(1'b1);
    n_tests++;
    if (fc[1] !== 16'h0000 || hc[1] !== 10'd0 || vc[1] !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_post: got frame_count=%h h=%0d v=%0d, want 0000 0 0", fc[1], hc[1], vc[1]);
    end
    for (int k = 0; k < 5; k++) drive_cycle(1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      en_v[i] = 1'b0;
      pr[i]   = 8'h00;
      pg[i]   = 8'h00;
      pb[i]   = 8'h00;
    end
    test_reset();
    test_default_lines();
    test_frames();
    test_pipe_pol();
    test_en_stall();
    test_reset_mid();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
